// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker: serial CRC-8 re-division of a {payload, crc} frame with valid/ready handshakes
module crc8_frame_checker #(
  parameter int BW = 40,
  parameter int CRC_BW = 8,
  parameter logic [CRC_BW-1:0] POLY = 8'h07,
  parameter int ERR_CNT_BW = 16,
  localparam int FW = BW + CRC_BW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FW-1:0]         in_frame,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BW-1:0]         out_data,
  output logic                  out_crc_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ERR_CNT_BW-1:0] err_cnt
);
  localparam int CW = $clog2(FW);
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] shift_q;
  logic [CRC_BW-1:0] rem_q, rem_next;
  logic [CW-1:0] cnt_q;
  logic last, accept;
  always_comb begin
    accept = state_q == IDLE && in_valid && in_ready;
    last = cnt_q == CW'(FW - 1);
    rem_next = {rem_q[CRC_BW-2:0], 1'b0} ^ ((rem_q[CRC_BW-1] ^ shift_q[FW-1]) ? POLY : '0);
    state_d = state_q == IDLE ? (accept ? CHECK : IDLE) :
              state_q == CHECK ? (last ? DONE : CHECK) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      in_ready <= state_d == IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      out_data <= '0;
      out_crc_ok <= 1'b0;
      out_valid <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (accept) begin
        shift_q <= in_frame;
        out_data <= in_frame[FW-1:CRC_BW];
        rem_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == CHECK) begin
        shift_q <= shift_q << 1;
        rem_q <= rem_next;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          out_crc_ok <= rem_next == '0;
          out_valid <= 1'b1;
        end
      end
      if (state_q == DONE && out_ready) begin
        out_valid <= 1'b0;
        if (!out_crc_ok && err_cnt != '1)
          err_cnt <= err_cnt + ERR_CNT_BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb_crc8_frame_checker: randomized frames checked against a polynomial-division model
module tb_crc8_frame_checker;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [47:0] in_frame = '0;
  logic in_ready, out_crc_ok, out_valid, s_in_ready, s_out_crc_ok, s_out_valid;
  logic [39:0] out_data, s_out_data;
  logic [15:0] err_cnt;
  logic [1:0] s_err_cnt;
  int total = 0, bad = 0;
  int cyc = 0, due = 0, m_err = 0, m_err_sat = 0;
  bit started = 0, pending = 0, m_ready = 0, m_valid = 0, m_ok = 0;
  logic [39:0] m_data = '0;
  logic [47:0] m_frame = '0;
  crc8_frame_checker dut (
    .clk(clk), .rst(rst), .in_frame(in_frame), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_crc_ok(out_crc_ok), .out_valid(out_valid),
    .out_ready(out_ready), .err_cnt(err_cnt)
  );
  crc8_frame_checker #(.ERR_CNT_BW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_frame(in_frame), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_crc_ok(s_out_crc_ok), .out_valid(s_out_valid),
    .out_ready(out_ready), .err_cnt(s_err_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] mod_g(input logic [47:0] f);
    logic [47:0] r;
    r = f;
    for (int i = 47; i >= 8; i--)
      if (r[i]) r = r ^ (48'h107 << (i - 8));
    return r[7:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    bit acc, dlv;
    cyc++;
    started = 1;
    acc = m_ready && in_valid;
    dlv = m_valid && out_ready;
    if (rst) begin
      pending = 0; m_valid = 0; m_ok = 0; m_data = '0; m_err = 0; m_err_sat = 0;
    end else begin
      if (dlv) begin
        m_valid = 0;
        if (!m_ok) begin
          m_err++;
          if (m_err_sat < 3) m_err_sat++;
        end
      end
      if (acc) begin
        pending = 1; due = cyc + 48; m_frame = in_frame; m_data = in_frame[47:8];
      end
      if (pending && cyc == due) begin
        pending = 0; m_valid = 1; m_ok = mod_g(m_frame) == 8'h0;
      end
    end
    m_ready = !rst && !pending && !m_valid;
  end
  always @(negedge clk) if (started) begin
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_crc_ok", out_crc_ok, m_ok);
    chk("err_cnt", err_cnt, m_err[15:0]);
    chk("err_cnt_sat", s_err_cnt, m_err_sat[1:0]);
    chk("sat_out_valid", s_out_valid, m_valid);
  end
  task automatic send(input logic [47:0] f);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_frame = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask
  initial begin
    int lat;
    logic [63:0] r64;
    logic [39:0] p;
    logic [47:0] f;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, n;
    logic [63:0] r64;
    logic [39:0] p;
    logic [47:0] f;
    chk("pin_good_frame", {56'h0, mod_g(48'h0000_0000_0107)}, 0);
    chk("pin_bad_frame", {56'h0, mod_g(48'h0000_0000_0106)}, 1);
    chk("pin_crc_of_1", {56'h0, mod_g({40'h1, 8'h0})}, 64'h07);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_data", out_data, 0);
    send(48'h0000_0000_0107);
    wait_out(lat);
    chk("latency", lat, 48);
    chk("good_data", out_data, 40'h1);
    chk("good_ok", out_crc_ok, 1);
    @(posedge clk); #1;
    chk("good_err", err_cnt, 0);
    send(48'h0000_0000_0106);
    wait_out(lat);
    chk("bad_ok", out_crc_ok, 0);
    @(posedge clk); #1;
    chk("bad_err", err_cnt, 1);
    out_ready = 1'b0;
    send(48'h0);
    wait_out(lat);
    for (int i = 0; i < 20; i++) begin
      in_frame = 48'h0000_0000_0107;
      in_valid = i == 5 || i == 6;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 0);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", out_valid, 0);
    chk("bp_in_ready_after", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      send(48'h0000_0000_00FF);
      wait_out(lat);
      @(posedge clk); #1;
    end
    chk("sat_err", s_err_cnt, 2'd3);
    chk("wide_err", err_cnt, 5);
    send({40'h12_3456_789A, mod_g({40'h12_3456_789A, 8'h0})});
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_pulse", out_valid, 0);
    send({40'hAB_CDEF_0123, mod_g({40'hAB_CDEF_0123, 8'h0})});
    wait_out(lat);
    chk("after_abort_ok", out_crc_ok, 1);
    chk("after_abort_data", out_data, 40'hAB_CDEF_0123);
    for (int k = 0; k < 30; k++) begin
      r64 = {$urandom, $urandom};
      p = r64[39:0];
      f = {p, mod_g({p, 8'h0})};
      if ($urandom_range(0, 1) == 1) f = f ^ (48'h1 << $urandom_range(0, 47));
      send(f);
      n = 0;
      do begin
        out_ready = $urandom_range(0, 1) == 1;
        @(posedge clk); #1; n++;
      end while (!in_ready && n < 500);
      chk("rand_frame_done", in_ready, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
